// File: rtl/ram_sp_be_pkg.sv
// Shared defaults and state encoding for the byte-enable single-port RAM.
// Optional per-byte parity is selected with the RAM_PARITY_EN macro.
package ram_sp_be_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned RD_LAT_DEF = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Even parity: the stored bit makes the byte plus parity have an even number of ones.
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_sp_be_if.sv
// Request/response bundle of ram_sp_be; par_err exists only with RAM_PARITY_EN.
interface ram_sp_be_if
  import ram_sp_be_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic                  en;
  logic                  wr_rd;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic [DATA_W-1:0]     data_out;
  logic                  en_out;
`ifdef RAM_PARITY_EN
  logic                  par_err;

  modport master (output en, wr_rd, addr, data_in, be,
                  input  ready, data_out, en_out, par_err);
  modport slave  (input  en, wr_rd, addr, data_in, be,
                  output ready, data_out, en_out, par_err);
`else
  modport master (output en, wr_rd, addr, data_in, be,
                  input  ready, data_out, en_out);
  modport slave  (input  en, wr_rd, addr, data_in, be,
                  output ready, data_out, en_out);
`endif

endinterface

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: STAGES registers of valid+data, flushed by async reset.
module ram_rd_pipe #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [STAGES-1:0] vld_q;
  logic [W-1:0]      data_q [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      data_q[0] <= in_vld ? in_data : '0;
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[STAGES-1];
  assign out_data = data_q[STAGES-1];

endmodule

// File: rtl/ram_sp_be.sv
// Single-port RAM with byte enables, self-clearing INIT after reset and pipelined reads.
// Define RAM_PARITY_EN to add per-byte even parity storage and the par_err output.
module ram_sp_be
  import ram_sp_be_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  ram_sp_be_if.slave  bus
);

  localparam int unsigned NB = DATA_W / 8;
`ifdef RAM_PARITY_EN
  localparam int unsigned PIPE_W = DATA_W + 1;
`else
  localparam int unsigned PIPE_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_we;
  logic              ready;
  logic              in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [PIPE_W-1:0] rd_pipe_in;
  logic [PIPE_W-1:0] rd_pipe_out;
  logic              rd_pipe_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    ready     = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: ready = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  assign in_range = 32'(bus.addr) < DEPTH;
  assign wr_acc   = bus.en & ready & bus.wr_rd & in_range;
  assign rd_acc   = bus.en & ready & ~bus.wr_rd;
  assign bus.ready = ready;

  // No reset on the array itself: INIT walks every word after each reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < int'(NB); i++)
        if (bus.be[i]) mem[bus.addr][8*i +: 8] <= bus.data_in[8*i +: 8];
    end
  end

  assign rd_word = in_range ? mem[bus.addr] : '0;

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par_calc;
  logic          rd_perr;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < int'(NB); i++)
        if (bus.be[i]) par_mem[bus.addr][i] <= par8(bus.data_in[8*i +: 8]);
    end
  end

  always_comb begin
    rd_par_calc = '0;
    for (int i = 0; i < int'(NB); i++) rd_par_calc[i] = par8(rd_word[8*i +: 8]);
  end

  assign rd_perr       = in_range && (rd_par_calc != par_mem[bus.addr]);
  assign rd_pipe_in    = {rd_perr, rd_word};
  assign bus.par_err   = rd_pipe_vld & rd_pipe_out[DATA_W];
`else
  assign rd_pipe_in    = rd_word;
`endif

  ram_rd_pipe #(
    .STAGES (RD_LAT),
    .W      (PIPE_W)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc),
    .in_data  (rd_pipe_in),
    .out_vld  (rd_pipe_vld),
    .out_data (rd_pipe_out)
  );

  assign bus.en_out   = rd_pipe_vld;
  assign bus.data_out = rd_pipe_vld ? rd_pipe_out[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_ram_sp_be.sv
// Directed self-checking bench for ram_sp_be (default build, plus a DEPTH=12 instance).
module tb_ram_sp_be;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ram_sp_be_if #(.ADDR_W(4), .DATA_W(32)) bus ();
  ram_sp_be_if #(.ADDR_W(4), .DATA_W(32)) bus12 ();

  ram_sp_be #(.ADDR_W(4), .DATA_W(32), .DEPTH(16), .RD_LAT(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ram_sp_be #(.ADDR_W(4), .DATA_W(32), .DEPTH(12), .RD_LAT(2)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    bus.en = 1'b1; bus.wr_rd = 1'b1; bus.addr = a; bus.data_in = d; bus.be = b;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic write12(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    bus12.en = 1'b1; bus12.wr_rd = 1'b1; bus12.addr = a; bus12.data_in = d; bus12.be = b;
    tick();
    bus12.en = 1'b0;
  endtask

  // Accept at edge A; with RD_LAT=2 the pulse is visible after edge A+1 and gone after A+2.
  task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus.en = 1'b1; bus.wr_rd = 1'b0; bus.addr = a;
    tick();
    bus.en = 1'b0;
    check({tag, "_lat"}, 32'(bus.en_out), 32'd0);
    tick();
    check({tag, "_vld"}, 32'(bus.en_out), 32'd1);
    check({tag, "_data"}, bus.data_out, exp);
    tick();
    check({tag, "_end"}, 32'(bus.en_out), 32'd0);
    check({tag, "_zero"}, bus.data_out, 32'd0);
  endtask

  task automatic read12_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus12.en = 1'b1; bus12.wr_rd = 1'b0; bus12.addr = a;
    tick();
    bus12.en = 1'b0;
    tick();
    check({tag, "_vld"}, 32'(bus12.en_out), 32'd1);
    check({tag, "_data"}, bus12.data_out, exp);
    tick();
    check({tag, "_end"}, 32'(bus12.en_out), 32'd0);
  endtask

  initial begin
    int cyc;
    int cyc12;
    logic saw;

    rst = 1'b0;
    bus.en = 1'b0;   bus.wr_rd = 1'b0;   bus.addr = '0;   bus.data_in = '0;   bus.be = '0;
    bus12.en = 1'b0; bus12.wr_rd = 1'b0; bus12.addr = '0; bus12.data_in = '0; bus12.be = '0;
    repeat (3) tick();
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_en_out", 32'(bus.en_out), 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);

    // INIT length: ready after DEPTH edges following release.
    rst = 1'b1;
    cyc = 0;
    cyc12 = 0;
    while (!bus.ready && cyc < 100) begin
      tick();
      cyc++;
      if (bus12.ready && cyc12 == 0) cyc12 = cyc;
    end
    check("init_cycles_d16", cyc, 16);
    check("init_cycles_d12", cyc12, 12);

    read_chk("rd5_after_init", 4'd5, 32'h0000_0000);

    write(4'd3, 32'hDEAD_BEEF, 4'hF);
    write(4'd3, 32'h1122_3344, 4'h5);
    read_chk("rd3_byte_merge", 4'd3, 32'hDE22_BE44);

    write(4'd3, 32'hFFFF_FFFF, 4'h0);
    read_chk("rd3_be_zero", 4'd3, 32'hDE22_BE44);

    // Back-to-back reads come out on consecutive cycles in order.
    write(4'd1, 32'h0000_00A1, 4'hF);
    write(4'd2, 32'h0000_00A2, 4'hF);
    write(4'd3, 32'h0000_00A3, 4'hF);
    bus.en = 1'b1; bus.wr_rd = 1'b0; bus.addr = 4'd1;
    tick();
    check("b2b_lat", 32'(bus.en_out), 32'd0);
    bus.addr = 4'd2;
    tick();
    check("b2b_vld1", 32'(bus.en_out), 32'd1);
    check("b2b_data1", bus.data_out, 32'h0000_00A1);
    bus.addr = 4'd3;
    tick();
    bus.en = 1'b0;
    check("b2b_vld2", 32'(bus.en_out), 32'd1);
    check("b2b_data2", bus.data_out, 32'h0000_00A2);
    tick();
    check("b2b_vld3", 32'(bus.en_out), 32'd1);
    check("b2b_data3", bus.data_out, 32'h0000_00A3);
    tick();
    check("b2b_end", 32'(bus.en_out), 32'd0);

    write(4'd7, 32'hCAFE_F00D, 4'hF);
    read_chk("rd7_after_wr", 4'd7, 32'hCAFE_F00D);

    write12(4'd11, 32'h1357_9BDF, 4'hF);
    read12_chk("d12_rd11_last", 4'd11, 32'h1357_9BDF);
    write12(4'd15, 32'h2468_ACE0, 4'hF);
    read12_chk("d12_rd15_oob", 4'd15, 32'h0000_0000);

`ifdef RAM_PARITY_EN
    write(4'd2, 32'h0F0F_0F0F, 4'hF);
    u_dut.mem[2][0] = ~u_dut.mem[2][0];
    bus.en = 1'b1; bus.wr_rd = 1'b0; bus.addr = 4'd2;
    tick();
    bus.en = 1'b0;
    tick();
    check("par_bad_vld", 32'(bus.en_out), 32'd1);
    check("par_bad_err", 32'(bus.par_err), 32'd1);
    tick();
    check("par_bad_end", 32'(bus.par_err), 32'd0);
    bus.en = 1'b1; bus.wr_rd = 1'b0; bus.addr = 4'd7;
    tick();
    bus.en = 1'b0;
    tick();
    check("par_ok_vld", 32'(bus.en_out), 32'd1);
    check("par_ok_err", 32'(bus.par_err), 32'd0);
    tick();
`endif

    // Reset one cycle after a read is accepted: the read must never appear.
    write(4'd9, 32'h55AA_55AA, 4'hF);
    bus.en = 1'b1; bus.wr_rd = 1'b0; bus.addr = 4'd9;
    tick();
    bus.en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrd_rst_ready", 32'(bus.ready), 32'd0);
    check("midrd_rst_en_out", 32'(bus.en_out), 32'd0);
    tick();
    check("midrd_rst_hold", 32'(bus.en_out), 32'd0);
    tick();
    rst = 1'b1;

    // Write requests during INIT must be ignored, and no stale read may surface.
    bus.wr_rd = 1'b1; bus.addr = 4'd4; bus.data_in = 32'hFFFF_FFFF; bus.be = 4'hF;
    cyc = 0;
    saw = 1'b0;
    while (!bus.ready && cyc < 100) begin
      bus.en = (cyc < 5);
      tick();
      cyc++;
      if (bus.en_out) saw = 1'b1;
    end
    bus.en = 1'b0;
    check("reinit_cycles", cyc, 16);
    check("reinit_no_en_out", 32'(saw), 32'd0);

    read_chk("rd9_after_rst", 4'd9, 32'h0000_0000);
    read_chk("rd4_init_ignored", 4'd4, 32'h0000_0000);
    read_chk("rd7_after_rst", 4'd7, 32'h0000_0000);
    read12_chk("d12_rd11_after_rst", 4'd11, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sp_be.md
RAM_SP_BE -- requirements
Module: ram_sp_be

Interface
REQ-001 Parameter ADDR_W, default 4, address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 16, number of words; SHALL be at most 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 2, read latency in cycles; legal range 1..4.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  request strobe; request accepted on a rising edge when en=1 and ready=1.
REQ-008 wr_rd  input  1  1 = write, 0 = read; sampled with en.
REQ-009 addr  input  ADDR_W  word address; sampled with en.
REQ-010 data_in  input  DATA_W  write data; sampled with en.
REQ-011 be  input  DATA_W/8  byte write enables; bit i covers data_in[8i+7:8i].
REQ-012 ready  output  1  block can accept a request this cycle.
REQ-013 data_out  output  DATA_W  read data; valid only while en_out=1.
REQ-014 en_out  output  1  one-cycle pulse marking read data valid.

Function
REQ-015 Block SHALL have states INIT and IDLE; ready=1 only in IDLE.
REQ-016 INIT: a clear counter SHALL write zero to words 0..DEPTH-1, one per cycle, then move to IDLE; INIT lasts exactly DEPTH cycles.
REQ-017 Requests with en=1 while ready=0 SHALL be ignored, not queued.
REQ-018 Accepted write: only bytes with be[i]=1 updated at the accepting edge; be=0 is a legal no-op.
REQ-019 Accepted read: en_out=1 and data_out valid exactly RD_LAT cycles after the accepting edge.
REQ-020 Reads SHALL be fully pipelined: one request per cycle, en_out pulses in request order.
REQ-021 Read accepted the cycle after a write to the same address SHALL return the written data.
REQ-022 addr >= DEPTH: write SHALL be dropped; read SHALL still pulse en_out with data_out=0.
REQ-023 data_out SHALL be 0 whenever en_out=0.

Reset
REQ-024 rst=0 SHALL immediately force ready=0, en_out=0, data_out=0, clear counter=0, read pipeline flushed, state=INIT.
REQ-025 Reset mid-read SHALL drop all in-flight reads; no en_out for them after reset release.
REQ-026 After rst returns to 1, INIT SHALL run again from word 0.

Configuration
REQ-027 Macro RAM_PARITY_EN: when defined, each word stores one even-parity bit per byte, updated on byte write and in INIT, and output par_err (1 bit) SHALL pulse with en_out when any stored byte's parity mismatches on read; par_err reset value 0.
REQ-028 Without RAM_PARITY_EN: no parity storage, no par_err port, behaviour otherwise identical.

Structure
REQ-029 Shared package/defines SHALL hold the defaults for ADDR_W, DATA_W, DEPTH, RD_LAT and the INIT/IDLE state encoding.
REQ-030 Read delay line SHALL be sub-module ram_rd_pipe (RD_LAT stages of valid+data, async-reset flush).

Verification (DATA_W=32, ADDR_W=4, DEPTH=16, RD_LAT=2)
REQ-031 Release reset, count ready -> ready rises after exactly 16 cycles; read addr 5 -> data_out=0x00000000.
REQ-032 Write addr 3 data 0xDEADBEEF be=0xF, then write addr 3 data 0x11223344 be=0x5, read addr 3 -> data_out=0xDE22BE44 two cycles after accept.
REQ-033 Back-to-back reads addr 1,2,3 after writes 0xA1,0xA2,0xA3 -> en_out high three consecutive cycles, data 0xA1,0xA2,0xA3.
REQ-034 Write addr 7 0xCAFEF00D, read addr 7 next cycle -> 0xCAFEF00D; read addr 15 at DEPTH=12 -> en_out=1, data_out=0.
REQ-035 Accept read then assert rst one cycle later -> en_out stays 0, ready=0, INIT restarts, earlier written data reads 0 afterwards.
REQ-036 With RAM_PARITY_EN, force one stored bit flip at addr 2 -> read pulses par_err=1 with en_out; clean address -> par_err=0.
